// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if
//   Groups the rPLL-facing lock/reset signals and the system reset/status
//   outputs of the lock supervisor into one bundle.
//   Signals:
//     pll_lock        rPLL LOCK, asynchronous to clkin (into the supervisor)
//     pll_reset       rPLL RESET, active-high
//     sys_rst         system reset, active-high
//     locked_ok       1 while the PLL lock is qualified and in use
//     lock_lost_pulse one-cycle pulse when lock drops while running
//     retry_cnt       saturating count of lock timeouts
//     fail            1 once the retry budget is exhausted
//   Modports: master = supervisor side, slave = PLL/consumer side.
interface pll_lock_supervisor_if;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst;
  logic       locked_ok;
  logic       lock_lost_pulse;
  logic [3:0] retry_cnt;
  logic       fail;

  modport master (
    input  pll_lock,
    output pll_reset, sys_rst, locked_ok, lock_lost_pulse, retry_cnt, fail
  );

  modport slave (
    output pll_lock,
    input  pll_reset, sys_rst, locked_ok, lock_lost_pulse, retry_cnt, fail
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Drives the rPLL RESET pin, synchronises and qualifies the asynchronous
//   LOCK output over a stability window, retries the PLL on lock timeout and
//   holds the system reset until a stable lock has been seen.
//   Ports:
//     clkin   reference clock (sole clock)
//     reset   synchronous, active-high
//     pll_if  supervisor side of pll_lock_supervisor_if (see interface file)
//   All outputs are registered; pll_lock only reaches them through the
//   synchroniser and the state register.
module pll_lock_supervisor #(
  parameter int unsigned LOCK_SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                   clkin,
  input  logic                   reset,
  pll_lock_supervisor_if.master  pll_if
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned RTY_W   = 4;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [RTY_W-1:0]              retry_q, retry_d;
  logic [LOCK_SYNC_STAGES-1:0]   sync_q;
  logic                          lock_sync;
  logic [RTY_W-1:0]              retry_inc;

  logic pll_reset_q, pll_reset_d;
  logic sys_rst_q,   sys_rst_d;
  logic locked_ok_q, locked_ok_d;
  logic lost_q,      lost_d;
  logic fail_q,      fail_d;

  assign lock_sync = sync_q[LOCK_SYNC_STAGES-1];
  assign retry_inc = (retry_q == {RTY_W{1'b1}}) ? retry_q : retry_q + RTY_W'(1);

  // Synchroniser, state, counters and registered outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_q      <= '0;
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_ok_q <= 1'b0;
      lost_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_if.pll_lock};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_ok_q <= locked_ok_d;
      lost_q      <= lost_d;
      fail_q      <= fail_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register
  // in step with the state they belong to
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lost_d      = 1'b0;
    pll_reset_d = 1'b1;
    sys_rst_d   = 1'b1;
    locked_ok_d = 1'b0;
    fail_d      = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // A lock arriving on the last timeout cycle still wins
        if (lock_sync) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          if ((MAX_RETRIES != 0) && (32'(retry_inc) >= MAX_RETRIES)) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_sync) begin
          state_d = ST_PLL_RST;
          lost_d  = 1'b1;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      ST_WAIT_LOCK, ST_STABLE: begin
        pll_reset_d = 1'b0;
      end
      ST_RUN: begin
        pll_reset_d = 1'b0;
        sys_rst_d   = 1'b0;
        locked_ok_d = 1'b1;
      end
      ST_FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
        pll_reset_d = 1'b1;
      end
    endcase
  end

  assign pll_if.pll_reset       = pll_reset_q;
  assign pll_if.sys_rst         = sys_rst_q;
  assign pll_if.locked_ok       = locked_ok_q;
  assign pll_if.lock_lost_pulse = lost_q;
  assign pll_if.retry_cnt       = retry_q;
  assign pll_if.fail            = fail_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Drives reset/pll_lock cycle by cycle (directed corner sequences followed
//   by random segments). A behavioural model of the lock supervision rules
//   predicts the outputs after each edge and queues them; a monitor on the
//   falling edge pops and compares against the DUT.
module tb_pll_lock_supervisor;

  localparam int unsigned P_SYNC    = 2;
  localparam int unsigned P_RST     = 4;
  localparam int unsigned P_STABLE  = 8;
  localparam int unsigned P_TIMEOUT = 32;
  localparam int unsigned P_RETRIES = 2;

  logic clkin = 1'b0;
  logic reset = 1'b1;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .LOCK_SYNC_STAGES   (P_SYNC),
    .PLL_RST_CYCLES     (P_RST),
    .LOCK_STABLE_CYCLES (P_STABLE),
    .LOCK_TIMEOUT_CYCLES(P_TIMEOUT),
    .MAX_RETRIES        (P_RETRIES)
  ) dut (
    .clkin (clkin),
    .reset (reset),
    .pll_if(bus)
  );

  always #10 clkin = ~clkin;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // {pll_reset, sys_rst, locked_ok, lock_lost_pulse, retry_cnt[3:0], fail}
  logic [8:0] exp_q[$];

  // Reference model: phase + cycles spent in it, lock seen through a delay line
  typedef enum int {M_PLLRST, M_WAIT, M_STABLE, M_RUN, M_FAIL} phase_e;
  phase_e m_phase = M_PLLRST;
  int     m_spent = 0;
  int     m_retries = 0;
  bit     m_lost = 0;
  bit     m_delay[$];

  function automatic void m_enter(input phase_e p);
    m_phase = p;
    m_spent = 0;
  endfunction

  function automatic void model_edge(input bit r, input bit l);
    bit ls;
    if (r) begin
      m_enter(M_PLLRST);
      m_retries = 0;
      m_lost = 0;
      m_delay.delete();
      for (int i = 0; i < int'(P_SYNC); i++) m_delay.push_back(1'b0);
      return;
    end
    ls = m_delay.pop_front();
    m_delay.push_back(l);
    m_lost = 0;
    case (m_phase)
      M_PLLRST: begin
        m_spent++;
        if (m_spent == int'(P_RST)) m_enter(M_WAIT);
      end
      M_WAIT: begin
        if (ls) m_enter(M_STABLE);
        else begin
          m_spent++;
          if (m_spent == int'(P_TIMEOUT)) begin
            if (m_retries < 15) m_retries++;
            if (P_RETRIES != 0 && m_retries >= int'(P_RETRIES)) m_enter(M_FAIL);
            else m_enter(M_PLLRST);
          end
        end
      end
      M_STABLE: begin
        if (!ls) m_enter(M_WAIT);
        else begin
          m_spent++;
          if (m_spent == int'(P_STABLE)) m_enter(M_RUN);
        end
      end
      M_RUN: begin
        if (!ls) begin
          m_lost = 1;
          m_enter(M_PLLRST);
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [8:0] model_out();
    logic [3:0] r;
    r = 4'(m_retries);
    return {(m_phase == M_PLLRST || m_phase == M_FAIL),
            (m_phase != M_RUN),
            (m_phase == M_RUN),
            m_lost,
            r,
            (m_phase == M_FAIL)};
  endfunction

  // One clock: apply inputs, let the edge happen, queue the prediction
  task automatic step(input bit r, input bit l);
    reset        = r;
    bus.pll_lock = l;
    @(posedge clkin);
    #1;
    model_edge(r, l);
    exp_q.push_back(model_out());
    cycle++;
  endtask

  task automatic hold(input bit l, input int n);
    for (int i = 0; i < n; i++) step(1'b0, l);
  endtask

  // Monitor: compare DUT outputs with the queued prediction each cycle
  initial begin
    logic [8:0] exp_v;
    logic [8:0] act_v;
    forever begin
      @(negedge clkin);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        act_v = {bus.pll_reset, bus.sys_rst, bus.locked_ok, bus.lock_lost_pulse,
                 bus.retry_cnt, bus.fail};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle %0d: got rst=%b sys=%b ok=%b lost=%b retry=%0d fail=%b, want rst=%b sys=%b ok=%b lost=%b retry=%0d fail=%b",
                   cycle, act_v[8], act_v[7], act_v[6], act_v[5], act_v[4:1], act_v[0],
                   exp_v[8], exp_v[7], exp_v[6], exp_v[5], exp_v[4:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    int mode;
    bus.pll_lock = 1'b0;

    // Reset, then lock first seen on the last cycle of the timeout window
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    hold(1'b0, 33);
    hold(1'b1, 20);
    // Lock loss in RUN, recovery
    hold(1'b0, 1);
    hold(1'b1, 25);
    // Glitch during the stability window
    hold(1'b0, 1);
    hold(1'b1, 10);
    hold(1'b0, 1);
    hold(1'b1, 20);
    // Lock arrives one cycle too late: timeout wins, then recovery
    step(1'b1, 1'b0);
    hold(1'b0, 34);
    hold(1'b1, 30);
    // Reset while in RUN
    step(1'b1, 1'b1);
    hold(1'b0, 4);
    hold(1'b0, 120);
    // Stuck in FAIL with lock present, then reset out of it
    hold(1'b1, 20);
    step(1'b1, 1'b1);
    hold(1'b1, 30);

    // Random segments
    for (int s = 0; s < 60; s++) begin
      mode = int'($urandom_range(0, 5));
      case (mode)
        0: hold(1'b1, int'($urandom_range(5, 40)));
        1: hold(1'b0, int'($urandom_range(5, 80)));
        2: for (int i = 0; i < 20; i++) step(1'b0, ($urandom_range(0, 3) != 0));
        3: begin
          hold(1'b0, int'($urandom_range(1, 2)));
          hold(1'b1, int'($urandom_range(6, 16)));
        end
        4: step(1'b1, 1'($urandom_range(0, 1)));
        default: hold(1'b0, int'($urandom_range(60, 160)));
      endcase
    end

    @(negedge clkin);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
